i2c_regmap: RTL
===============

I2C_REGMAP -- requirements
Module: i2c_regmap

Interface
REQ-001 SHALL have parameter REG_COUNT, default 16, number of 8-bit registers (power of two, 2..256).
REQ-002 SHALL have parameter PTR_W, default 4, pointer width, equal to log2(REG_COUNT).
REQ-003 clk  in  1  system clock, same clock as the I2C slave.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 busy  in  1  slave busy, high from START to end of transaction.
REQ-006 data_available  in  1  slave write-ACK level, held high for multiple clk cycles.
REQ-007 data_o  in  8  byte received by the slave, valid while data_available is high.
REQ-008 data_request  in  1  slave read-request level, held high for multiple clk cycles.
REQ-009 data_i  out  8  byte offered to the slave for transmission.
REQ-010 host_addr  in  PTR_W  local register address.
REQ-011 host_we  in  1  local write enable.
REQ-012 host_wdata  in  8  local write data.
REQ-013 host_rdata  out  8  registered read data at host_addr.
REQ-014 wr_pulse  out  1  one-cycle strobe when an I2C write updates a register.
REQ-015 wr_addr  out  PTR_W  index of the register updated by the last I2C write.

Function
REQ-016 SHALL detect rising edges of busy, data_available and data_request using 1-cycle delayed copies, so each level pulse acts exactly once.
REQ-017 SHALL use the states IDLE, GET_PTR and DATA: busy rise goes to GET_PTR; busy fall from any state goes to IDLE.
REQ-018 SHALL, in GET_PTR on a data_available rise, load pointer with data_o[PTR_W-1:0] and go to DATA; upper bits are ignored.
REQ-019 SHALL, in DATA on a data_available rise, write data_o to regs[pointer], pulse wr_pulse, set wr_addr to the pointer, then advance the pointer.
REQ-020 SHALL drive data_i with regs[pointer], registered, updated every cycle with 1-cycle latency.
REQ-021 SHALL not advance the pointer on the first data_request rise of a transaction, because that rise belongs to the address ACK.
REQ-022 SHALL advance the pointer on each later data_request rise in the same transaction, because each such rise is a master ACK.
REQ-023 SHALL leave the pointer unchanged after the final master-NACKed byte.
REQ-024 SHALL wrap the pointer from REG_COUNT-1 to 0.
REQ-025 SHALL keep the pointer value across transactions; a read with no preceding pointer write starts at the retained pointer.
REQ-026 SHALL give the I2C write priority over host_we when both target the same register in the same cycle; different registers both update.
REQ-027 SHALL update host_rdata one cycle after host_addr; host_rdata reflects writes made in the previous cycle.
REQ-028 SHALL ignore data_available and data_request edges while in IDLE.

Reset
REQ-029 SHALL, on rst low, immediately set: state IDLE; pointer 0; all registers 0x00; data_i 0x00; host_rdata 0x00; wr_pulse 0; wr_addr 0; all edge-detect registers 0.
REQ-030 SHALL, on reset mid-transaction, discard the transaction and treat the next busy rise as a new transaction.

Configuration
REQ-031 SHALL, with macro I2C_REGMAP_AUTOINC_EN defined, advance the pointer as in REQ-019 and REQ-022.
REQ-032 SHALL, without I2C_REGMAP_AUTOINC_EN, never advance the pointer: repeated writes hit one register and repeated reads return the same register.

Structure
REQ-033 SHALL take from shared package i2c_pkg: the regmap state encoding, the default REG_COUNT, and the reset value 8'h00.
REQ-034 SHALL instantiate one sub-module, i2c_edge_det, a rising-edge detector, once per monitored input.

Verification
REQ-035 Write 0x03,0xAA,0xBB -> regs[3]=0xAA, regs[4]=0xBB, two wr_pulses, pointer=5.
REQ-036 Write ptr 0x03, repeated START read of 3 bytes with ACK,ACK,NACK -> data_i sequence 0xAA, 0xBB, regs[5]; final pointer=5.
REQ-037 Write ptr 0x0F, data 0x11,0x22 -> regs[15]=0x11, regs[0]=0x22 (wrap).
REQ-038 I2C write and host_we to reg 2 in the same cycle (0x55 vs 0x66) -> regs[2]=0x55.
REQ-039 rst low during the second data byte -> all outputs 0; the next transaction behaves as after power-up.
REQ-040 Without I2C_REGMAP_AUTOINC_EN, write ptr 0x01, data 0x10,0x20 -> regs[1]=0x20, regs[2]=0x00.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: register-map FSM encoding, default map size and register reset value.
package i2c_pkg;

    typedef enum logic [1:0] {
        REGMAP_IDLE    = 2'd0,
        REGMAP_GET_PTR = 2'd1,
        REGMAP_DATA    = 2'd2
    } regmap_state_e;

    localparam int         REGMAP_REG_COUNT_DEF = 16;
    localparam logic [7:0] REGMAP_RST_VAL       = 8'h00;

endpackage

// File: rtl/i2c_edge_det.sv
// Rising-edge detector: one-cycle pulse the first cycle sig_i is seen high after being low.
module i2c_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/i2c_regmap.sv
// Register file behind an I2C slave: first written byte sets the pointer, later bytes read/write regs.
// Define I2C_REGMAP_AUTOINC_EN to advance the pointer after each data byte and each master ACK.
module i2c_regmap
    import i2c_pkg::*;
#(
    parameter int REG_COUNT = REGMAP_REG_COUNT_DEF,
    parameter int PTR_W     = $clog2(REG_COUNT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             busy,
    input  logic             data_available,
    input  logic [7:0]       data_o,
    input  logic             data_request,
    output logic [7:0]       data_i,
    input  logic [PTR_W-1:0] host_addr,
    input  logic             host_we,
    input  logic [7:0]       host_wdata,
    output logic [7:0]       host_rdata,
    output logic             wr_pulse,
    output logic [PTR_W-1:0] wr_addr
);

`ifdef I2C_REGMAP_AUTOINC_EN
    localparam logic [PTR_W-1:0] PTR_STEP = PTR_W'(1);
`else
    localparam logic [PTR_W-1:0] PTR_STEP = PTR_W'(0);
`endif

    localparam int EDGE_BUSY  = 0;
    localparam int EDGE_AVAIL = 1;
    localparam int EDGE_REQ   = 2;

    logic [2:0]       mon_w;
    logic [2:0]       rise_w;
    regmap_state_e    state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             req_seen_q, req_seen_d;
    logic             i2c_we;
    logic [7:0]       data_i_q, host_rdata_q;
    logic             wr_pulse_q;
    logic [PTR_W-1:0] wr_addr_q;
    logic [7:0]       regs_w [REG_COUNT];

    assign mon_w = {data_request, data_available, busy};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_edge
            i2c_edge_det u_edge (
                .clk    (clk),
                .rst_n  (rst),
                .sig_i  (mon_w[gi]),
                .rise_o (rise_w[gi])
            );
        end
    endgenerate

    // The I2C write is tested first so it wins a same-register collision with the host.
    generate
        for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg
            logic [7:0] reg_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    reg_q <= REGMAP_RST_VAL;
                end else if (i2c_we && (ptr_q == PTR_W'(gi))) begin
                    reg_q <= data_o;
                end else if (host_we && (host_addr == PTR_W'(gi))) begin
                    reg_q <= host_wdata;
                end
            end
            assign regs_w[gi] = reg_q;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        req_seen_d = req_seen_q;
        i2c_we     = 1'b0;
        if (rise_w[EDGE_BUSY]) begin
            state_d    = REGMAP_GET_PTR;
            req_seen_d = 1'b0;
        end else if (!busy) begin
            state_d = REGMAP_IDLE;
        end else begin
            unique case (state_q)
                REGMAP_GET_PTR: begin
                    if (rise_w[EDGE_AVAIL]) begin
                        ptr_d   = data_o[PTR_W-1:0];
                        state_d = REGMAP_DATA;
                    end
                end
                REGMAP_DATA: begin
                    if (rise_w[EDGE_AVAIL]) begin
                        i2c_we = 1'b1;
                        ptr_d  = ptr_q + PTR_STEP;
                    end
                end
                default: ;
            endcase
            // First request of a transaction is the address ACK; later ones are master ACKs.
            if ((state_q != REGMAP_IDLE) && rise_w[EDGE_REQ] && !rise_w[EDGE_AVAIL]) begin
                req_seen_d = 1'b1;
                if (req_seen_q) begin
                    ptr_d = ptr_q + PTR_STEP;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= REGMAP_IDLE;
            ptr_q        <= '0;
            req_seen_q   <= 1'b0;
            data_i_q     <= REGMAP_RST_VAL;
            host_rdata_q <= REGMAP_RST_VAL;
            wr_pulse_q   <= 1'b0;
            wr_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            req_seen_q   <= req_seen_d;
            data_i_q     <= regs_w[ptr_q];
            host_rdata_q <= regs_w[host_addr];
            wr_pulse_q   <= i2c_we;
            if (i2c_we) begin
                wr_addr_q <= ptr_q;
            end
        end
    end

    assign data_i     = data_i_q;
    assign host_rdata = host_rdata_q;
    assign wr_pulse   = wr_pulse_q;
    assign wr_addr    = wr_addr_q;

endmodule
